// File: rtl/csa_pkg.sv
// Shared types and helpers for the bit-serial carry-save adder datapath:
// frame FSM states, default operand width and bit-counter sizing.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Counter must reach WIDTH (the flush index), hence w+1.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/csa_piso.sv
// WIDTH-bit parallel-in / serial-out register, shifting right (LSB first).
// The vacated MSB is filled from ext_in so the flush bit can be sign or zero.
module csa_piso
  import csa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic             ext_in,
  input  logic [WIDTH-1:0] load_data,
  output logic             lsb,
  output logic             msb
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_data;
    end else if (shift) begin
      data_d = {ext_in, data_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign lsb = data_q[0];
  assign msb = data_q[WIDTH-1];

endmodule

// File: rtl/csa_operand_serializer.sv
// Serializes an operand pair LSB-first into the carry-save adder, framing each
// pair with a one-cycle clr and ending it with a flush bit for the final carry.
module csa_operand_serializer
  import csa_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int SIGN_EXT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             in_ready,
  output logic             x,
  output logic             y,
  output logic             clr,
  output logic             bit_valid,
  output logic             bit_last,
  output logic             busy
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH);

  // Handshake: a pair transfers on any rising edge where in_valid && in_ready;
  // in_ready is a function of registered state only, never of in_valid.

  state_e        state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          load;
  logic          shift;
  logic          accept;
  logic          flush;
  logic          a_lsb, a_msb, b_lsb, b_msb;
  logic          a_ext, b_ext;

  assign a_ext = (SIGN_EXT != 0) ? a_msb : 1'b0;
  assign b_ext = (SIGN_EXT != 0) ? b_msb : 1'b0;

  csa_piso #(.WIDTH(WIDTH)) u_piso_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .shift     (shift),
    .ext_in    (a_ext),
    .load_data (in_a),
    .lsb       (a_lsb),
    .msb       (a_msb)
  );

  csa_piso #(.WIDTH(WIDTH)) u_piso_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .shift     (shift),
    .ext_in    (b_ext),
    .load_data (in_b),
    .lsb       (b_lsb),
    .msb       (b_msb)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    load     = 1'b0;
    shift    = 1'b0;
    flush    = (state_q == SHIFT) && (idx_q == LAST_IDX);
    in_ready = (state_q == IDLE) || flush;
    accept   = in_valid && in_ready;

    case (state_q)
      IDLE: begin
        if (accept) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        idx_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (flush) begin
          idx_d = '0;
          if (accept) begin
            load    = 1'b1;
            state_d = CLEAR;
          end else begin
            state_d = IDLE;
          end
        end else begin
          // Shift registers stay put during flush; their ext fill is the flush bit.
          shift = 1'b1;
          idx_d = idx_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign clr       = (state_q == CLEAR);
  assign bit_valid = (state_q == SHIFT);
  assign bit_last  = flush;
  assign busy      = (state_q != IDLE);
  assign x         = (state_q == SHIFT) ? a_lsb : 1'b0;
  assign y         = (state_q == SHIFT) ? b_lsb : 1'b0;

endmodule
